// File: rtl/atb_funnel.sv
// N-input ATB trace funnel: round-robin arbitration with bounded hold per source,
// a registered master port, flush fan-out/fan-in, syncreq broadcast and wakeup aggregation.
module atb_funnel #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 7,
   parameter int HOLD      = 4,
   parameter int BYTES_W   = $clog2(DATA_W / 8)
) (
   input  logic                          atclk,
   input  logic                          atresetn,
   input  logic                          atclken,
   input  logic [NUM_PORTS*DATA_W-1:0]   s_atdata,
   input  logic [NUM_PORTS*BYTES_W-1:0]  s_atbytes,
   input  logic [NUM_PORTS*ID_W-1:0]     s_atid,
   input  logic [NUM_PORTS-1:0]          s_atvalid,
   output logic [NUM_PORTS-1:0]          s_atready,
   output logic [NUM_PORTS-1:0]          s_afvalid,
   input  logic [NUM_PORTS-1:0]          s_afready,
   output logic [NUM_PORTS-1:0]          s_syncreq,
   input  logic [NUM_PORTS-1:0]          s_atwakeup,
   output logic [DATA_W-1:0]             m_atdata,
   output logic [BYTES_W-1:0]            m_atbytes,
   output logic [ID_W-1:0]               m_atid,
   output logic                          m_atvalid,
   input  logic                          m_atready,
   input  logic                          m_afvalid,
   output logic                          m_afready,
   input  logic                          m_syncreq,
   output logic                          m_atwakeup
);

   localparam int CUR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ACK   = 2'd2
   } flush_state_t;

   logic [CUR_W-1:0]     cur;
   logic [CNT_W-1:0]     cnt;
   logic [CUR_W-1:0]     win;
   logic [CUR_W-1:0]     cand;
   logic                 any_valid;
   logic                 sticky;
   logic [NUM_PORTS-1:0] sel;
   logic [DATA_W-1:0]    mux_data;
   logic [BYTES_W-1:0]   mux_bytes;
   logic [ID_W-1:0]      mux_id;
   logic                 out_free;
   logic                 load;
   flush_state_t         state;
   logic [NUM_PORTS-1:0] done;

   assign sticky = s_atvalid[cur] && (cnt < CNT_W'(HOLD));

   // Search starts at cur+1 and wraps onto cur last, so a lone port that has
   // used up its hold budget still wins again.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      win       = '0;
      cand      = '0;
      any_valid = 1'b0;
      if (sticky) begin
         win       = cur;
         any_valid = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = CUR_W'((int'(cur) + k) % NUM_PORTS);
            if (!any_valid && s_atvalid[cand]) begin
               win       = cand;
               any_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel       = '0;
      mux_data  = '0;
      mux_bytes = '0;
      mux_id    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (any_valid && (win == CUR_W'(i))) begin
            sel[i]    = 1'b1;
            mux_data  = s_atdata[i*DATA_W +: DATA_W];
            mux_bytes = s_atbytes[i*BYTES_W +: BYTES_W];
            mux_id    = s_atid[i*ID_W +: ID_W];
         end
      end
   end

   assign out_free  = ~m_atvalid | m_atready;
   assign load      = atclken & out_free & any_valid;
   assign s_atready = (atclken && out_free) ? sel : '0;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         m_atdata  <= '0;
         m_atbytes <= '0;
         m_atid    <= '0;
         m_atvalid <= 1'b0;
         cur       <= '0;
         cnt       <= '0;
      end else if (atclken) begin
         if (load) begin
            m_atdata  <= mux_data;
            m_atbytes <= mux_bytes;
            m_atid    <= mux_id;
            m_atvalid <= 1'b1;
            cur       <= win;
            if ((win == cur) && (cnt < CNT_W'(HOLD)))
               cnt <= cnt + CNT_W'(1);
            else
               cnt <= CNT_W'(1);
         end else if (m_atready) begin
            m_atvalid <= 1'b0;
         end
      end
   end

   // Flush completes only once every slave has acked and the output register
   // has nothing left in it that predates the acknowledgement.
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         state     <= ST_IDLE;
         done      <= '0;
         m_afready <= 1'b0;
         s_syncreq <= '0;
      end else if (atclken) begin
         s_syncreq <= {NUM_PORTS{m_syncreq}};
         case (state)
            ST_IDLE: begin
               m_afready <= 1'b0;
               if (m_afvalid)
                  state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               done <= done | (s_afvalid & s_afready);
               if ((&done) && out_free) begin
                  state     <= ST_ACK;
                  m_afready <= 1'b1;
               end
            end
            ST_ACK: begin
               m_afready <= 1'b0;
               done      <= '0;
               state     <= ST_IDLE;
            end
            default: begin
               m_afready <= 1'b0;
               done      <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_afvalid  = (state == ST_FLUSH) ? ~done : '0;
   assign m_atwakeup = (|s_atwakeup) | m_atvalid | (state != ST_IDLE);

endmodule

// File: tb/tb_atb_funnel.sv
// Directed bench for atb_funnel: streaming, round-robin hold, clock enable,
// flush handshake, asynchronous reset, syncreq and wakeup.
module tb_atb_funnel;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int IW = 7;
   localparam int BW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             atclken;
   logic [NP*DW-1:0] s_atdata;
   logic [NP*BW-1:0] s_atbytes;
   logic [NP*IW-1:0] s_atid;
   logic [NP-1:0]    s_atvalid;
   logic [NP-1:0]    s_atready;
   logic [NP-1:0]    s_afvalid;
   logic [NP-1:0]    s_afready;
   logic [NP-1:0]    s_syncreq;
   logic [NP-1:0]    s_atwakeup;
   logic [DW-1:0]    m_atdata;
   logic [BW-1:0]    m_atbytes;
   logic [IW-1:0]    m_atid;
   logic             m_atvalid;
   logic             m_atready;
   logic             m_afvalid;
   logic             m_afready;
   logic             m_syncreq;
   logic             m_atwakeup;

   int errors = 0;
   int checks = 0;
   int sent;
   int recv;
   logic take;
   logic [3:0] rr_pat [10];
   int ack_t [4];
   logic [3:0] exp_af;

   atb_funnel #(.NUM_PORTS(NP), .DATA_W(DW), .ID_W(IW), .HOLD(4)) dut (
      .atclk      (clk),
      .atresetn   (rst_n),
      .atclken    (atclken),
      .s_atdata   (s_atdata),
      .s_atbytes  (s_atbytes),
      .s_atid     (s_atid),
      .s_atvalid  (s_atvalid),
      .s_atready  (s_atready),
      .s_afvalid  (s_afvalid),
      .s_afready  (s_afready),
      .s_syncreq  (s_syncreq),
      .s_atwakeup (s_atwakeup),
      .m_atdata   (m_atdata),
      .m_atbytes  (m_atbytes),
      .m_atid     (m_atid),
      .m_atvalid  (m_atvalid),
      .m_atready  (m_atready),
      .m_afvalid  (m_afvalid),
      .m_afready  (m_afready),
      .m_syncreq  (m_syncreq),
      .m_atwakeup (m_atwakeup)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] d, input logic [6:0] id);
      s_atdata[p*DW +: DW]  = d;
      s_atid[p*IW +: IW]    = id;
      s_atbytes[p*BW +: BW] = 2'd3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b1;
      atclken    = 1'b1;
      s_atdata   = '0;
      s_atbytes  = '0;
      s_atid     = '0;
      s_atvalid  = '0;
      s_afready  = '0;
      s_atwakeup = '0;
      m_atready  = 1'b0;
      m_afvalid  = 1'b0;
      m_syncreq  = 1'b0;
      rr_pat = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      ack_t  = '{2, 5, 3, 7};
      #2 rst_n = 1'b0;
      cyc();
      cyc();
      check("rst_m_atvalid", m_atvalid, 0);
      check("rst_m_afready", m_afready, 0);
      check("rst_s_afvalid", s_afvalid, 0);
      check("rst_s_syncreq", s_syncreq, 0);
      check("rst_m_atdata", m_atdata, 0);
      check("rst_wakeup", m_atwakeup, 0);
      check("rst_s_atready", s_atready, 0);
      rst_n = 1'b1;
      cyc();

      // Single port stream on port 2.
      m_atready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_port(2, 32'hA5A5_0001 + k, 7'h12);
         s_atvalid = 4'b0100;
         #1;
         check("single_rdy", s_atready, 4'b0100);
         cyc();
         check("single_valid", m_atvalid, 1);
         check("single_data", m_atdata, 32'hA5A5_0001 + k);
         check("single_id", m_atid, 7'h12);
      end
      s_atvalid = '0;
      #1;
      check("single_idle_rdy", s_atready, 0);
      cyc();
      check("single_drain", m_atvalid, 0);

      // Round-robin with hold of 4 between ports 0 and 1.
      set_port(0, 32'h0000_0A00, 7'h20);
      set_port(1, 32'h0000_0B01, 7'h21);
      s_atvalid = 4'b0011;
      for (int j = 0; j < 10; j++) begin
         #1;
         check("rr_grant", s_atready, rr_pat[j]);
         cyc();
         check("rr_data", m_atdata, rr_pat[j][0] ? 32'h0000_0A00 : 32'h0000_0B01);
      end
      m_atready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         check("stall_rdy", s_atready, 0);
         check("stall_valid", m_atvalid, 1);
         check("stall_data", m_atdata, 32'h0000_0A00);
         cyc();
      end
      m_atready = 1'b1;
      #1;
      check("resume_grant", s_atready, 4'b0001);
      cyc();
      check("resume_data", m_atdata, 32'h0000_0A00);
      s_atvalid = '0;
      cyc();
      check("rr_drain", m_atvalid, 0);

      // Clock enable held low for 5 cycles mid-stream on port 1.
      sent = 0;
      recv = 0;
      for (int c = 0; c < 60 && recv < 8; c++) begin
         atclken   = !(c >= 3 && c < 8);
         s_atvalid = (sent < 8) ? 4'b0010 : 4'b0000;
         set_port(1, 32'hC0DE_0000 + sent, 7'h31);
         #1;
         if (!atclken) check("clken_rdy", s_atready, 0);
         take = s_atready[1];
         if (atclken && m_atvalid && m_atready) begin
            check("clken_seq", m_atdata, 32'hC0DE_0000 + recv);
            recv++;
         end
         cyc();
         if (take) sent++;
      end
      atclken = 1'b1;
      check("clken_recv", recv, 8);
      check("clken_sent", sent, 8);

      // Flush with staggered slave acks while port 3 keeps streaming.
      for (int t = 0; t <= 14; t++) begin
         m_afvalid = (t <= 12);
         m_atready = !(t >= 6 && t <= 10);
         s_atvalid = (t <= 9) ? 4'b1000 : 4'b0000;
         for (int i = 0; i < 4; i++) s_afready[i] = (t == ack_t[i]);
         set_port(3, 32'hF1F1_0000 + t, 7'h33);
         #1;
         for (int i = 0; i < 4; i++) exp_af[i] = (t >= 1 && t <= ack_t[i]);
         check("flush_s_afvalid", s_afvalid, exp_af);
         check("flush_m_afready", m_afready, (t == 12));
         if (t == 12) check("flush_wakeup_ack", m_atwakeup, 1);
         if (t == 14) begin
            check("flush_wakeup_idle", m_atwakeup, 0);
            check("flush_drained", m_atvalid, 0);
         end
         cyc();
      end

      // Asynchronous reset while holding data and mid-flush.
      s_afready = '0;
      set_port(0, 32'h1234_5678, 7'h05);
      s_atvalid = 4'b0001;
      m_atready = 1'b0;
      m_afvalid = 1'b1;
      m_syncreq = 1'b1;
      cyc();
      cyc();
      check("pre_rst_valid", m_atvalid, 1);
      check("pre_rst_afvalid", s_afvalid, 4'b1111);
      check("pre_rst_sync", s_syncreq, 4'b1111);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", m_atvalid, 0);
      check("mid_rst_data", m_atdata, 0);
      check("mid_rst_id", m_atid, 0);
      check("mid_rst_afvalid", s_afvalid, 0);
      check("mid_rst_sync", s_syncreq, 0);
      check("mid_rst_afready", m_afready, 0);
      s_atvalid = '0;
      m_afvalid = 1'b0;
      m_syncreq = 1'b0;
      cyc();
      rst_n = 1'b1;
      set_port(0, 32'hBEEF_0001, 7'h05);
      s_atvalid = 4'b0001;
      m_atready = 1'b1;
      #1;
      check("restart_rdy", s_atready, 4'b0001);
      cyc();
      check("restart_valid", m_atvalid, 1);
      check("restart_data", m_atdata, 32'hBEEF_0001);
      s_atvalid = '0;
      cyc();
      check("restart_drain", m_atvalid, 0);

      // Syncreq broadcast and wakeup aggregation.
      m_syncreq = 1'b1;
      #1;
      check("sync_before", s_syncreq, 0);
      cyc();
      m_syncreq = 1'b0;
      check("sync_pulse", s_syncreq, 4'b1111);
      cyc();
      check("sync_after", s_syncreq, 0);
      s_atwakeup = 4'b1000;
      #1;
      check("wakeup_on", m_atwakeup, 1);
      s_atwakeup = '0;
      #1;
      check("wakeup_off", m_atwakeup, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
